lock_unlock_ctrl: RTL and testbench
===================================

Name: lock_unlock_ctrl

Overview:
- Upstream stage of the lock-on-reset register; generates its `unlock` input.
- Accepts a multi-word key over a valid/ready stream and compares it against a compile-time key.
- On a full match, asserts `unlock` until relocked. Counts failed attempts and enters permanent lockout after MAX_FAIL failures.
- Secure default: `unlock` is low from reset.

Parameters:
- KEY_W, 8, bits per key word
- KEY_LEN, 4, words per key sequence
- KEY, 32'hA5C3_0F96, expected key (KEY_W*KEY_LEN bits); word i = KEY[i*KEY_W +: KEY_W], word 0 sent first
- MAX_FAIL, 3, failed attempts before lockout (>=1)
- UNLOCK_CYCLES, 16, unlock window length (used only with the optional feature)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- key_valid  in  1  key word offered
- key_data  in  KEY_W  key word
- key_ready  out  1  controller accepts a word this cycle
- relock  in  1  request to return to the locked state / abort a partial sequence
- unlock  out  1  drives the downstream lock register's unlock input
- lockout  out  1  permanent lockout indicator
- fail_cnt  out  $clog2(MAX_FAIL+1)  failed attempts since the last success or reset

Behaviour:
- Interface: one clock (`clk`); reset is asynchronous and active-high (`reset`).
- Reset values: state=LOCKED, unlock=0, lockout=0, fail_cnt=0, word index=0, mismatch flag=0. Reset asserted mid-sequence or while unlocked forces these values immediately, without waiting for a clock edge.
- Handshake: a word transfers when key_valid && key_ready at a rising edge. key_data is ignored otherwise.
- key_ready is combinational from state: 1 only in LOCKED.
- States:
  - LOCKED:
    - On transfer: compare key_data with word[idx]; set the sticky mismatch flag on inequality; increment idx.
    - When the transfer is word KEY_LEN-1:
      - If no mismatch (including this word): go to UNLOCKED, clear fail_cnt.
      - Else if fail_cnt+1 == MAX_FAIL: go to LOCKOUT and increment fail_cnt.
      - Else: increment fail_cnt and stay in LOCKED.
      - In every case clear idx and the mismatch flag.
    - relock in LOCKED: clears idx and mismatch, no fail counted. If relock coincides with a transfer, relock wins and the word is discarded.
  - UNLOCKED:
    - unlock=1, key_ready=0.
    - relock=1 at an edge goes to LOCKED; unlock=0 from the next cycle.
  - LOCKOUT:
    - unlock=0, key_ready=0, lockout=1.
    - relock is ignored; only reset exits.
- Latency: unlock rises in the cycle after the edge that accepts the final matching word (registered output).
- Outputs are registered or decoded from the state register only; key_data never reaches unlock combinationally.
- fail_cnt saturates at MAX_FAIL.

Optional Feature:
- Macro: LOCK_CTRL_TIMEOUT_EN.
- Defined:
  - A down-counter loads UNLOCK_CYCLES on entry to UNLOCKED and decrements each cycle.
  - unlock stays high for exactly UNLOCK_CYCLES cycles, then the block returns to LOCKED automatically.
  - relock still ends the window early.
- Undefined: no counter; UNLOCKED persists until relock or reset.

Decomposition:
- Package lock_ctrl_pkg: state enum (LOCKED, UNLOCKED, LOCKOUT) and the default key/width localparams.
- One natural sub-module: key_seq_cmp (idx counter plus sticky mismatch; outputs seq_done and seq_match). The FSM lives in the top.

Test Plan:
- Reset, then send 96,0F,C3,A5 with key_valid held high: unlock=0 during the transfer cycles; unlock=1 in the cycle after the 4th transfer; fail_cnt=0.
- While unlocked, pulse relock: unlock=0 the next cycle, key_ready=1. Re-send the correct key: unlock=1 again.
- Send 96,0F,C3,A4 three times: fail_cnt steps 1, 2, 3. After the 3rd attempt, lockout=1 and key_ready=0. The correct key afterwards keeps unlock=0. Reset clears lockout and fail_cnt.
- Send 96,0F, pulse relock, then the full correct key: unlock=1 and fail_cnt=0 (abort is not counted as a failure).
- Deassert key_valid between words (gaps of 0–3 cycles): the result is identical to back-to-back words. Assert reset asynchronously (between edges) while unlocked: unlock drops immediately.
- With LOCK_CTRL_TIMEOUT_EN defined: after a correct key, unlock=1 for exactly 16 cycles, then unlock=0 and key_ready=1 with no relock.

Source files
------------

// File: rtl/lock_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// lock_ctrl_pkg
// Shared definitions for the key-based unlock controller:
//   - lock_state_e : controller state encoding (LOCKED, UNLOCKED, LOCKOUT)
//   - DEF_*        : default key geometry, key value, failure limit and
//                    unlock window length used as parameter defaults.
// -----------------------------------------------------------------------------
package lock_ctrl_pkg;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        UNLOCKED = 2'd1,
        LOCKOUT  = 2'd2
    } lock_state_e;

    localparam int          DEF_KEY_W         = 8;
    localparam int          DEF_KEY_LEN       = 4;
    // Word 0 lives in the least significant byte and is sent first.
    localparam logic [31:0] DEF_KEY           = 32'hA5C3_0F96;
    localparam int          DEF_MAX_FAIL      = 3;
    localparam int          DEF_UNLOCK_CYCLES = 16;

endpackage : lock_ctrl_pkg

// File: rtl/key_seq_cmp.sv
// -----------------------------------------------------------------------------
// key_seq_cmp
// Tracks the position inside a multi-word key sequence and remembers whether
// any word seen so far differed from the expected key.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous, active-high reset
//   clear_i      in   abort the current sequence (wins over xfer_i)
//   xfer_i       in   a key word is accepted this cycle
//   data_i       in   key word [KEY_W]
//   seq_done_o   out  this transfer is the last word of the sequence
//   seq_match_o  out  every word so far, including data_i, matched the key
//                     (meaningful together with seq_done_o)
// -----------------------------------------------------------------------------
module key_seq_cmp #(
    parameter int                         KEY_W   = 8,
    parameter int                         KEY_LEN = 4,
    parameter logic [KEY_W*KEY_LEN-1:0]   KEY     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             xfer_i,
    input  logic [KEY_W-1:0] data_i,
    output logic             seq_done_o,
    output logic             seq_match_o
);

    localparam int IDX_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

    logic [IDX_W-1:0] idx_q, idx_d;
    logic             mismatch_q, mismatch_d;
    logic [KEY_W-1:0] exp_word;
    logic             last_word;

    // Select the expected word for the current position.
    always_comb begin
        exp_word = '0;
        for (int i = 0; i < KEY_LEN; i++) begin
            if (idx_q == IDX_W'(i)) begin
                exp_word = KEY[i*KEY_W +: KEY_W];
            end
        end
    end

    assign last_word   = (idx_q == IDX_W'(KEY_LEN - 1));
    assign seq_done_o  = xfer_i && last_word;
    assign seq_match_o = !mismatch_q && (data_i == exp_word);

    // NOTE: every variable driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        idx_d      = idx_q;
        mismatch_d = mismatch_q;
        if (clear_i || seq_done_o) begin
            idx_d      = '0;
            mismatch_d = 1'b0;
        end else if (xfer_i) begin
            idx_d      = idx_q + 1'b1;
            mismatch_d = mismatch_q || (data_i != exp_word);
        end
    end

    // NOTE: state registers use non-blocking assignments and an asynchronous
    // reset so reset takes effect without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q      <= '0;
            mismatch_q <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            mismatch_q <= mismatch_d;
        end
    end

endmodule : key_seq_cmp

// File: rtl/lock_unlock_ctrl.sv
// -----------------------------------------------------------------------------
// lock_unlock_ctrl
// Accepts a KEY_LEN-word key over a valid/ready stream, compares it with a
// compile-time key and drives the unlock input of the downstream lock
// register. Failed attempts are counted; MAX_FAIL failures lock the block out
// until reset. unlock is low from reset and is decoded from the state
// register only, so key_data never reaches it combinationally.
//
// Optional build macro: LOCK_CTRL_TIMEOUT_EN
//   defined   : unlock stays high for exactly UNLOCK_CYCLES cycles, then the
//               block relocks by itself (relock still ends it early).
//   undefined : UNLOCKED persists until relock or reset.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high reset
//   key_valid  in   key word offered
//   key_data   in   key word [KEY_W]
//   key_ready  out  word accepted this cycle (high only in LOCKED)
//   relock     in   return to LOCKED / abort a partial sequence
//   unlock     out  unlock request to the downstream lock register
//   lockout    out  permanent lockout indicator
//   fail_cnt   out  failed attempts since last success or reset, saturating
// -----------------------------------------------------------------------------
module lock_unlock_ctrl
    import lock_ctrl_pkg::*;
#(
    parameter int                       KEY_W         = DEF_KEY_W,
    parameter int                       KEY_LEN       = DEF_KEY_LEN,
    parameter logic [KEY_W*KEY_LEN-1:0] KEY           = DEF_KEY,
    parameter int                       MAX_FAIL      = DEF_MAX_FAIL,
    parameter int                       UNLOCK_CYCLES = DEF_UNLOCK_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          key_valid,
    input  logic [KEY_W-1:0]              key_data,
    output logic                          key_ready,
    input  logic                          relock,
    output logic                          unlock,
    output logic                          lockout,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

    localparam int FC_W = $clog2(MAX_FAIL + 1);

    if (MAX_FAIL < 1 || UNLOCK_CYCLES < 1) begin : g_bad_params
        $error("lock_unlock_ctrl: MAX_FAIL and UNLOCK_CYCLES must be >= 1");
    end

    lock_state_e     state_q, state_d;
    logic [FC_W-1:0] fail_cnt_q, fail_cnt_d;
    logic            xfer;
    logic            seq_done;
    logic            seq_match;
    logic            tmr_expired;

    // relock wins over a coincident transfer: the word is discarded.
    assign key_ready = (state_q == LOCKED);
    assign xfer      = key_valid && key_ready && !relock;

    key_seq_cmp #(
        .KEY_W   (KEY_W),
        .KEY_LEN (KEY_LEN),
        .KEY     (KEY)
    ) u_key_seq_cmp (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (relock),
        .xfer_i      (xfer),
        .data_i      (key_data),
        .seq_done_o  (seq_done),
        .seq_match_o (seq_match)
    );

`ifdef LOCK_CTRL_TIMEOUT_EN
    localparam int TMR_W = $clog2(UNLOCK_CYCLES + 1);

    logic [TMR_W-1:0] tmr_q, tmr_d;

    // Loaded on entry to UNLOCKED; the edge that sees 1 leaves the state, so
    // unlock is high for exactly UNLOCK_CYCLES cycles.
    always_comb begin
        tmr_d = tmr_q;
        if (state_q != UNLOCKED && state_d == UNLOCKED) begin
            tmr_d = TMR_W'(UNLOCK_CYCLES);
        end else if (state_q == UNLOCKED && tmr_q != '0) begin
            tmr_d = tmr_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

    assign tmr_expired = (tmr_q == TMR_W'(1));
`else
    assign tmr_expired = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        fail_cnt_d = fail_cnt_q;
        unique case (state_q)
            LOCKED: begin
                if (seq_done) begin
                    if (seq_match) begin
                        state_d    = UNLOCKED;
                        fail_cnt_d = '0;
                    end else begin
                        if (fail_cnt_q != FC_W'(MAX_FAIL)) begin
                            fail_cnt_d = fail_cnt_q + 1'b1;
                        end
                        if (fail_cnt_q == FC_W'(MAX_FAIL - 1)) begin
                            state_d = LOCKOUT;
                        end
                    end
                end
            end
            UNLOCKED: begin
                if (relock || tmr_expired) begin
                    state_d = LOCKED;
                end
            end
            LOCKOUT: begin
                state_d = LOCKOUT;
            end
            // Unused encoding: fall back to the secure locked state.
            default: begin
                state_d = LOCKED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= LOCKED;
            fail_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign unlock   = (state_q == UNLOCKED);
    assign lockout  = (state_q == LOCKOUT);
    assign fail_cnt = fail_cnt_q;

endmodule : lock_unlock_ctrl

// File: tb/tb_lock_unlock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lock_unlock_ctrl
// Directed bench for lock_unlock_ctrl with default parameters
// (key A5C30F96, words sent 96,0F,C3,A5; MAX_FAIL=3; UNLOCK_CYCLES=16).
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge.
// -----------------------------------------------------------------------------
module tb_lock_unlock_ctrl;

    localparam logic [31:0] GOOD_KEY = 32'hA5C3_0F96;
    localparam logic [31:0] BAD_KEY  = 32'hA4C3_0F96;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [7:0] key_data;
    logic       key_ready;
    logic       relock;
    logic       unlock;
    logic       lockout;
    logic [1:0] fail_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    lock_unlock_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .key_valid (key_valid),
        .key_data  (key_data),
        .key_ready (key_ready),
        .relock    (relock),
        .unlock    (unlock),
        .lockout   (lockout),
        .fail_cnt  (fail_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Send the first n_words words of key k, with gap idle cycles before
    // word i when gapped is set (gap = i, giving 0..3 idle cycles).
    task automatic send_key(input logic [31:0] k, input int n_words, input bit gapped);
        for (int i = 0; i < n_words; i++) begin
            if (gapped) repeat (i) @(negedge clk);
            @(negedge clk);
            key_valid = 1'b1;
            key_data  = k[i*8 +: 8];
            @(posedge clk);
            #1;
            key_valid = 1'b0;
            key_data  = 8'h00;
        end
    endtask

    task automatic pulse_relock();
        @(negedge clk);
        relock = 1'b1;
        @(posedge clk);
        #1;
        relock = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        key_valid = 1'b0;
        key_data  = 8'h00;
        relock    = 1'b0;
        #1;
        // Reset state
        check("rst_unlock",    32'(unlock),    32'd0);
        check("rst_lockout",   32'(lockout),   32'd0);
        check("rst_fail_cnt",  32'(fail_cnt),  32'd0);
        check("rst_key_ready", 32'(key_ready), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Correct key back to back; unlock stays low until the 4th word lands.
        send_key(GOOD_KEY, 3, 1'b0);
        check("partial_unlock", 32'(unlock), 32'd0);
        @(negedge clk);
        key_valid = 1'b1;
        key_data  = 8'hA5;
        #2;
        check("last_word_comb", 32'(unlock), 32'd0);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        check("good_unlock",    32'(unlock),    32'd1);
        check("good_fail_cnt",  32'(fail_cnt),  32'd0);
        check("good_key_ready", 32'(key_ready), 32'd0);

        // Relock, then unlock again.
        pulse_relock();
        check("relock_unlock", 32'(unlock),    32'd0);
        check("relock_ready",  32'(key_ready), 32'd1);
        send_key(GOOD_KEY, 4, 1'b0);
        check("reunlock", 32'(unlock), 32'd1);
        pulse_relock();

        // Three bad attempts: 1, 2, then lockout at 3.
        send_key(BAD_KEY, 4, 1'b0);
        check("bad1_cnt",    32'(fail_cnt), 32'd1);
        check("bad1_unlock", 32'(unlock),   32'd0);
        check("bad1_ready",  32'(key_ready), 32'd1);
        send_key(BAD_KEY, 4, 1'b0);
        check("bad2_cnt",     32'(fail_cnt), 32'd2);
        check("bad2_lockout", 32'(lockout),  32'd0);
        send_key(BAD_KEY, 4, 1'b0);
        check("bad3_cnt",     32'(fail_cnt),  32'd3);
        check("bad3_lockout", 32'(lockout),   32'd1);
        check("bad3_ready",   32'(key_ready), 32'd0);
        pulse_relock();
        check("lockout_relock", 32'(lockout), 32'd1);
        send_key(GOOD_KEY, 4, 1'b0);
        check("lockout_good_unlock", 32'(unlock),   32'd0);
        check("lockout_cnt_sat",     32'(fail_cnt), 32'd3);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_clr_lockout", 32'(lockout),  32'd0);
        check("rst_clr_cnt",     32'(fail_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Abort a partial sequence: not counted as a failure.
        send_key(BAD_KEY, 4, 1'b0);
        check("pre_abort_cnt", 32'(fail_cnt), 32'd1);
        send_key(GOOD_KEY, 2, 1'b0);
        pulse_relock();
        check("abort_cnt", 32'(fail_cnt), 32'd1);
        send_key(GOOD_KEY, 4, 1'b0);
        check("abort_unlock", 32'(unlock),   32'd1);
        check("abort_cnt_clr", 32'(fail_cnt), 32'd0);
        pulse_relock();

        // Relock coinciding with a transfer discards the word.
        @(negedge clk);
        relock    = 1'b1;
        key_valid = 1'b1;
        key_data  = 8'h96;
        @(posedge clk);
        #1;
        relock    = 1'b0;
        key_valid = 1'b0;
        send_key(GOOD_KEY, 4, 1'b0);
        check("collide_unlock", 32'(unlock),   32'd1);
        check("collide_cnt",    32'(fail_cnt), 32'd0);
        pulse_relock();

        // Gaps of 0..3 idle cycles between words.
        send_key(BAD_KEY, 4, 1'b1);
        check("gap_bad_cnt", 32'(fail_cnt), 32'd1);
        send_key(GOOD_KEY, 4, 1'b1);
        check("gap_good_unlock", 32'(unlock),   32'd1);
        check("gap_good_cnt",    32'(fail_cnt), 32'd0);

`ifdef LOCK_CTRL_TIMEOUT_EN
        begin
            int high_cycles = 1;
            for (int c = 0; c < 40; c++) begin
                @(posedge clk);
                #1;
                if (!unlock) break;
                high_cycles++;
            end
            check("timeout_len",   32'(high_cycles), 32'd16);
            check("timeout_ready", 32'(key_ready),   32'd1);
        end
        send_key(GOOD_KEY, 4, 1'b0);
`else
        repeat (20) @(posedge clk);
        #1;
        check("persist_unlock", 32'(unlock), 32'd1);
`endif

        // Asynchronous reset between edges while unlocked.
        check("pre_async_unlock", 32'(unlock), 32'd1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_unlock", 32'(unlock),    32'd0);
        check("async_rst_ready",  32'(key_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_lock_unlock_ctrl
